// File: rtl/eth_hdr_mon_pkg.sv
// -----------------------------------------------------------------------------
// eth_hdr_mon_pkg
// Shared definitions for the 64b/66b sync-header error monitor:
//   - FSM state encoding (IDLE / RUN / DONE)
//   - legal sync header values (data and control)
//   - helper that classifies a 2-bit sync header as valid / invalid
// -----------------------------------------------------------------------------
package eth_hdr_mon_pkg;

   // Measurement FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Legal sync headers; 2'b00 and 2'b11 are the invalid encodings
   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   function automatic logic hdr_is_valid(input logic [1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

// File: rtl/eth_hdr_window_chk.sv
// -----------------------------------------------------------------------------
// eth_hdr_window_chk
// Fixed-window error-burst checker. Counts qualified headers in windows of
// WINDOW_LEN; when the last header of a window arrives, flags the window if
// its invalid-header count (including that last header) reached ERR_THRESH.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_clr        synchronous clear of the window state (start of a run)
//   i_hdr_valid  a header is being counted this cycle
//   i_hdr_bad    the counted header is invalid (only meaningful with i_hdr_valid)
//   o_window_err one-cycle pulse, combinational from the registered window
//                state and the current header, so the caller can register the
//                sticky flag on the same edge that counts the header
// -----------------------------------------------------------------------------
module eth_hdr_window_chk #(
   parameter int unsigned WINDOW_LEN = 64,
   parameter int unsigned ERR_THRESH = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_hdr_valid,
   input  logic i_hdr_bad,
   output logic o_window_err
);

   // Wide enough to hold WINDOW_LEN itself (invalid count of an all-bad window)
   localparam int unsigned   WW   = $clog2(WINDOW_LEN + 1);
   localparam logic [WW-1:0] LAST = WW'(WINDOW_LEN - 1);
   localparam logic [WW-1:0] ONE  = WW'(1);

   logic [WW-1:0] r_win_cnt;
   logic [WW-1:0] r_inv_cnt;
   logic [WW-1:0] w_inv_next;
   logic          w_win_end;

   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      w_inv_next   = i_hdr_bad ? (r_inv_cnt + ONE) : r_inv_cnt;
      w_win_end    = i_hdr_valid && (r_win_cnt == LAST);
      o_window_err = w_win_end && (32'(w_inv_next) >= ERR_THRESH);
   end

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_win_cnt <= '0;
         r_inv_cnt <= '0;
      end else if (i_hdr_valid) begin
         if (w_win_end) begin
            r_win_cnt <= '0;
            r_inv_cnt <= '0;
         end else begin
            r_win_cnt <= r_win_cnt + ONE;
            r_inv_cnt <= w_inv_next;
         end
      end
   end

endmodule

// File: rtl/eth_hdr_err_monitor.sv
// -----------------------------------------------------------------------------
// eth_hdr_err_monitor
// Measures sync-header quality over a run of TOTAL_HDR qualified headers.
// Ports:
//   rx_clk, rx_rst              clock / synchronous active-high reset
//   serdes_rx_hdr, hdr_valid    header under test and its qualifier
//   rx_block_lock               PHY block-lock status
//   start                       pulse that begins a run (ignored while busy)
//   busy, done                  run in progress / run finished
//   count_valid, count_invalid  header counts for the run (saturating)
//   max_consec_valid            longest run of consecutive valid headers
//   lock_latency, lock_seen     header index of the first locked header
//   hi_err                      sticky: some full window hit ERR_THRESH errors
// All outputs are registered and reflect a header one cycle after it is
// qualified.
// -----------------------------------------------------------------------------
module eth_hdr_err_monitor
   import eth_hdr_mon_pkg::*;
#(
   parameter int unsigned HDR_WIDTH  = 2,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned TOTAL_HDR  = 500,
   parameter int unsigned WINDOW_LEN = 64,
   parameter int unsigned ERR_THRESH = 16
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   input  logic                 hdr_valid,
   input  logic                 rx_block_lock,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] count_valid,
   output logic [CNT_WIDTH-1:0] count_invalid,
   output logic [CNT_WIDTH-1:0] max_consec_valid,
   output logic [CNT_WIDTH-1:0] lock_latency,
   output logic                 lock_seen,
   output logic                 hi_err
);

   localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] LAST_HDR = CNT_WIDTH'(TOTAL_HDR - 1);

   logic [1:0]           r_state;
   logic                 r_busy;
   logic                 r_done;
   logic [CNT_WIDTH-1:0] r_hdr_cnt;    // headers counted this run, never exceeds TOTAL_HDR
   logic [CNT_WIDTH-1:0] r_cnt_valid;
   logic [CNT_WIDTH-1:0] r_cnt_invalid;
   logic [CNT_WIDTH-1:0] r_consec;
   logic [CNT_WIDTH-1:0] r_max_consec;
   logic [CNT_WIDTH-1:0] r_lock_lat;
   logic                 r_lock_seen;
   logic                 r_hi_err;

   logic                 w_run_hdr;    // header counted this cycle
   logic                 w_hdr_ok;
   logic                 w_start_run;  // start accepted (only from IDLE / DONE)
   logic [CNT_WIDTH-1:0] w_consec_next;
   logic                 w_window_err;

   always_comb begin
      w_run_hdr     = (r_state == ST_RUN) && hdr_valid;
      w_hdr_ok      = hdr_is_valid(serdes_rx_hdr);
      w_start_run   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
      w_consec_next = '0;
      if (w_hdr_ok)
         w_consec_next = (r_consec == '1) ? r_consec : (r_consec + ONE);
   end

   eth_hdr_window_chk #(
      .WINDOW_LEN (WINDOW_LEN),
      .ERR_THRESH (ERR_THRESH)
   ) u_window_chk (
      .i_clk        (rx_clk),
      .i_rst        (rx_rst),
      .i_clr        (w_start_run),
      .i_hdr_valid  (w_run_hdr),
      .i_hdr_bad    (!w_hdr_ok),
      .o_window_err (w_window_err)
   );

   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         r_state       <= ST_IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_hdr_cnt     <= '0;
         r_cnt_valid   <= '0;
         r_cnt_invalid <= '0;
         r_consec      <= '0;
         r_max_consec  <= '0;
         r_lock_lat    <= '0;
         r_lock_seen   <= 1'b0;
         r_hi_err      <= 1'b0;
      end else if (w_start_run) begin
         // Headers qualified on the start cycle itself are deliberately dropped.
         r_state       <= ST_RUN;
         r_busy        <= 1'b1;
         r_done        <= 1'b0;
         r_hdr_cnt     <= '0;
         r_cnt_valid   <= '0;
         r_cnt_invalid <= '0;
         r_consec      <= '0;
         r_max_consec  <= '0;
         r_lock_lat    <= '0;
         r_lock_seen   <= 1'b0;
         r_hi_err      <= 1'b0;
      end else if (w_run_hdr) begin
         r_hdr_cnt <= r_hdr_cnt + ONE;

         if (w_hdr_ok) begin
            if (r_cnt_valid != '1)
               r_cnt_valid <= r_cnt_valid + ONE;
         end else begin
            if (r_cnt_invalid != '1)
               r_cnt_invalid <= r_cnt_invalid + ONE;
         end

         r_consec <= w_consec_next;
         if (w_consec_next > r_max_consec)
            r_max_consec <= w_consec_next;

         // r_hdr_cnt equals count_valid + count_invalid because TOTAL_HDR keeps
         // both below saturation; +1 includes the current header.
         if (rx_block_lock && !r_lock_seen) begin
            r_lock_seen <= 1'b1;
            r_lock_lat  <= r_hdr_cnt + ONE;
         end

         if (w_window_err)
            r_hi_err <= 1'b1;

         if (r_hdr_cnt == LAST_HDR) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end
      end
   end

   assign busy             = r_busy;
   assign done             = r_done;
   assign count_valid      = r_cnt_valid;
   assign count_invalid    = r_cnt_invalid;
   assign max_consec_valid = r_max_consec;
   assign lock_latency     = r_lock_lat;
   assign lock_seen        = r_lock_seen;
   assign hi_err           = r_hi_err;

endmodule

// File: doc/eth_hdr_err_monitor.md
ETH_HDR_ERR_MONITOR -- requirements
Module: eth_hdr_err_monitor

Interface
REQ-001 Parameter HDR_WIDTH, default 2, sync header width; only 2 is supported.
REQ-002 Parameter CNT_WIDTH, default 32, width of all header counters.
REQ-003 Parameter TOTAL_HDR, default 500, number of headers per measurement run (1..2^CNT_WIDTH-1).
REQ-004 Parameter WINDOW_LEN, default 64, fixed window length in headers for the error-burst check.
REQ-005 Parameter ERR_THRESH, default 16, invalid-header count per window that raises hi_err.
REQ-006 rx_clk  input  1  sole clock; all logic on the rising edge.
REQ-007 rx_rst  input  1  synchronous, active-high reset.
REQ-008 serdes_rx_hdr  input  HDR_WIDTH  sync header under test.
REQ-009 hdr_valid  input  1  qualifies serdes_rx_hdr for one cycle.
REQ-010 rx_block_lock  input  1  block-lock status from the PHY receiver.
REQ-011 start  input  1  single-cycle pulse that begins a run.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 done  output  1  high from run end until the next start or reset.
REQ-014 count_valid / count_invalid  output  CNT_WIDTH each  valid / invalid headers counted in the run.
REQ-015 max_consec_valid  output  CNT_WIDTH  longest run of consecutive valid headers.
REQ-016 lock_latency  output  CNT_WIDTH  headers counted up to and including the first with rx_block_lock high.
REQ-017 lock_seen  output  1  rx_block_lock was observed high during the run.
REQ-018 hi_err  output  1  sticky: some complete window reached ERR_THRESH invalid headers.

Function
REQ-019 Valid header: 2'b01 or 2'b10; invalid: 2'b00 or 2'b11.
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN and DONE->RUN on start; RUN->DONE on the cycle the TOTAL_HDR-th header is counted.
REQ-021 On the start cycle, all counters, lock_seen, hi_err, and window state clear; headers qualified by hdr_valid on that same cycle are not counted.
REQ-022 In RUN, each cycle with hdr_valid high increments exactly one of count_valid / count_invalid.
REQ-023 Consecutive-valid counter increments on a valid header, clears on an invalid one; max_consec_valid updates in the same cycle, so the output reflects the header one cycle after it is qualified.
REQ-024 On the first counted header with rx_block_lock high, lock_latency latches count_valid+count_invalid including that header, and lock_seen sets; neither changes again in the run.
REQ-025 Window counter counts qualified headers; invalid counter counts invalid ones; when WINDOW_LEN headers have been counted, hi_err sets if the invalid count (including the current header) >= ERR_THRESH; both counters then restart at 0.
REQ-026 A partial window at run end is not evaluated.
REQ-027 start asserted during RUN is ignored.
REQ-028 hdr_valid outside RUN has no effect.
REQ-029 Counters saturate at all-ones and do not wrap.
REQ-030 busy = (state==RUN); done = (state==DONE); all outputs are registered.
REQ-031 Latency: every output reflects a header one cycle after it is qualified; done rises one cycle after the final header.

Reset
REQ-032 rx_rst forces IDLE; all counters, lock_latency, lock_seen, hi_err, busy, and done reset to 0.
REQ-033 rx_rst mid-run aborts the run without asserting done; rx_rst takes priority over start.

Structure
REQ-034 Package eth_hdr_mon_pkg holds the FSM state enumeration and the sync header constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10.
REQ-035 Sub-module eth_hdr_window_chk implements REQ-025 and outputs a one-cycle window_err pulse.

Verification
REQ-036 TOTAL_HDR=500, every header 2'b10, block lock high from header 5 -> count_valid=500, count_invalid=0, max_consec_valid=500, lock_latency=5, hi_err=0, done=1.
REQ-037 Every 10th header 2'b11, others 2'b01, TOTAL_HDR=500 -> count_invalid=50, count_valid=450, max_consec_valid=9, hi_err=0.
REQ-038 WINDOW_LEN=64, ERR_THRESH=16, first 16 headers 2'b00 then valid -> hi_err set after header 64; stays set to end of run.
REQ-039 rx_rst pulsed after 200 headers, then start -> all outputs 0 after reset, done never asserted for the aborted run, new run counts from 0.
REQ-040 start pulsed again at header 100 -> ignored; hdr_valid held low for 20 cycles -> counts frozen; rx_block_lock never high -> lock_seen=0, lock_latency=0.
